// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with a bounded hold time and one
// turnaround cycle (gnt=0) between owners, so tristate drivers never overlap.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  // state | meaning
  // IDLE  | no owner, gnt=0, busy=0
  // OWN   | one requester owns the bus, gnt one-hot
  // GAP   | single turnaround cycle, gnt=0, busy=1
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [1:0] state;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;
  logic [1:0] winner;
  logic [1:0] rr_idx;
  logic       found;

  // sel doubles as the owner index; it is only reloaded on a new grant
  always_comb begin
    winner = ptr;
    rr_idx = ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = ptr + 2'(i);
      if (!found && req[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      ptr      <= 2'b00;
      hold_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (|req) begin
            gnt      <= 4'b0001 << winner;
            sel      <= winner;
            hold_cnt <= 4'd1;
            busy     <= 1'b1;
            state    <= ST_OWN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (req[sel] && (hold_cnt < HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else begin
            gnt   <= 4'b0000;
            ptr   <= sel + 2'd1;
            state <= ST_GAP;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed vector bench for bus_arbiter4 (MAX_HOLD=8 main instance, MAX_HOLD=1
// side instance) with a per-cycle grant-safety monitor on both.
module tb_bus_arbiter4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] gnt1;
  logic [1:0] sel1;
  logic       busy1;

  int checks = 0;
  int errors = 0;

  bus_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .sel(sel), .busy(busy)
  );

  bus_arbiter4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .sel(sel1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                     input logic [1:0] s, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endtask

  // one-hot-or-zero and no back-to-back different owners, every cycle
  logic [3:0] prev0 = 4'b0000;
  logic [3:0] prev1 = 4'b0000;
  always @(negedge clk) begin
    checks = checks + 1;
    if ((gnt & (gnt - 4'd1)) != 4'd0 || (prev0 != 4'd0 && gnt != 4'd0 && prev0 != gnt)) begin
      errors = errors + 1;
      $display("FAIL gnt_safety dut t=%0t: prev=%b gnt=%b, required one-hot/zero with gap between owners", $time, prev0, gnt);
    end
    checks = checks + 1;
    if ((gnt1 & (gnt1 - 4'd1)) != 4'd0 || (prev1 != 4'd0 && gnt1 != 4'd0 && prev1 != gnt1)) begin
      errors = errors + 1;
      $display("FAIL gnt_safety dut1 t=%0t: prev=%b gnt=%b, required one-hot/zero with gap between owners", $time, prev1, gnt1);
    end
    prev0 = gnt;
    prev1 = gnt1;
  end

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s step %0d: got %b, required %b", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    // reset held with all requests, then released
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    // full rotation with everyone requesting: 8 cycles each, gap between
    for (int i = 0; i < 7; i++) add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b1111, 4'b0000, 2'd0, 1);
    for (int i = 0; i < 8; i++) add(0, 4'b1111, 4'b0010, 2'd1, 1);
    add(0, 4'b1111, 4'b0000, 2'd1, 1);
    for (int i = 0; i < 8; i++) add(0, 4'b1111, 4'b0100, 2'd2, 1);
    add(0, 4'b1111, 4'b0000, 2'd2, 1);
    for (int i = 0; i < 8; i++) add(0, 4'b1111, 4'b1000, 2'd3, 1);
    add(0, 4'b1111, 4'b0000, 2'd3, 1);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    // single requester held 30 cycles: re-granted after each forced gap
    for (int i = 0; i < 30; i++)
      add(0, 4'b0100, ((i % 9) == 8) ? 4'b0000 : 4'b0100, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    // early release: req[0] dropped during the 3rd owned cycle
    add(0, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 4'b0010, 4'b0000, 2'd0, 1);
    add(0, 4'b0010, 4'b0010, 2'd1, 1);
    add(0, 4'b0000, 4'b0000, 2'd1, 1);
    add(0, 4'b0000, 4'b0000, 2'd1, 0);
    // reset mid-ownership at hold_cnt=4, then pointer is back at 0
    for (int i = 0; i < 4; i++) add(0, 4'b1000, 4'b1000, 2'd3, 1);
    add(1, 4'b1000, 4'b0000, 2'd0, 0);
    add(0, 4'b1001, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      @(posedge clk);
      #1;
      chk("gnt", i, gnt, vecs[i].gnt);
      chk("sel", i, {2'b00, sel}, {2'b00, vecs[i].sel});
      chk("busy", i, {3'b000, busy}, {3'b000, vecs[i].busy});
    end

    // MAX_HOLD=1: single-cycle grant, gap, re-grant, gap
    reset = 1'b1;
    req   = 4'b0001;
    @(posedge clk);
    #1;
    chk("h1_reset_gnt", 0, gnt1, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("h1_gnt", i, gnt1, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      chk("h1_busy", i, {3'b000, busy1}, 4'b0001);
    end
    req = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("h1_idle_busy", 0, {3'b000, busy1}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one requester may own the shared bus; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: bus request, where bit n is requester n.
REQ-005 The block SHALL have port gnt, output, 4 bits: registered one-hot grant that drives the tristate enables of the shared bus.
REQ-006 The block SHALL have port sel, output, 2 bits: registered binary index of the current or last owner.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the state is OWN or GAP.

Function
REQ-008 gnt SHALL always be one-hot or 4'b0000; two or more bits high at once is a defect, because it causes bus contention.
REQ-009 The FSM SHALL have three states: IDLE (no owner), OWN (gnt non-zero), GAP (one turnaround cycle with gnt=0).
REQ-010 Internal state SHALL be: 2-bit rotating priority pointer ptr, 4-bit hold counter hold_cnt, and the owner index.
REQ-011 Selection SHALL be round-robin: the winner is the first n with req[n]=1, searching ptr, ptr+1, ... modulo 4.
REQ-012 From IDLE or GAP, when req!=0 at an edge, the FSM SHALL load gnt=onehot(winner), sel=winner, hold_cnt=1 and go to OWN.
REQ-013 Grant latency SHALL be 1 cycle: a req sampled in IDLE produces gnt visible immediately after that edge.
REQ-014 From GAP with req=0, the FSM SHALL go to IDLE; from IDLE with req=0, it SHALL stay in IDLE.
REQ-015 In OWN, when req[owner]=1 and hold_cnt<MAX_HOLD at an edge, the FSM SHALL stay in OWN, increment hold_cnt, and leave gnt and sel unchanged.
REQ-016 In OWN, when req[owner]=0 or hold_cnt==MAX_HOLD at an edge, the FSM SHALL set gnt=0, set ptr=(owner+1) mod 4 with 3 wrapping to 0, and go to GAP.
REQ-017 An owner SHALL therefore hold the bus for at most MAX_HOLD consecutive cycles; MAX_HOLD=1 gives a single-cycle grant followed by a gap.
REQ-018 Every ownership change SHALL be separated by exactly one GAP cycle with gnt=0, including a re-grant to the same requester.
REQ-019 Requests from non-owners during OWN SHALL be ignored until GAP and SHALL NOT preempt the owner.
REQ-020 sel SHALL keep the last owner index while gnt=0 and is meaningful only when gnt!=0.
REQ-021 busy SHALL be registered, asserting with the first gnt and deasserting on the edge that enters IDLE.
REQ-022 hold_cnt SHALL NOT wrap; it saturates at MAX_HOLD, where release is forced.

Reset
REQ-023 When reset=1 at an edge, the block SHALL set state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, ptr=0 and hold_cnt=0, regardless of state or req.
REQ-024 Reset SHALL take priority over all transitions, including mid-ownership; there is no GAP cycle after reset.
REQ-025 The first edge with reset=0 SHALL evaluate req exactly as from IDLE.

Verification
REQ-026 Reset held with req=1111, then released: gnt=0000 and busy=0 during reset; gnt=0001, sel=00, busy=1 after the first non-reset edge.
REQ-027 MAX_HOLD=8, req=1111 held: grants SHALL follow 0001(x8), 0000, 0010(x8), 0000, 0100(x8), 0000, 1000(x8), 0000, 0001, i.e. wrap from 3 to 0.
REQ-028 req=0100 held for 30 cycles: gnt=0100 for 8 cycles, one 0000 gap cycle, then 0100 again, with busy=1 throughout.
REQ-029 req=0011, with req[0] dropped on the 3rd owned cycle: gnt=0001 for 3 cycles, 0000 for 1 cycle, then 0010.
REQ-030 reset pulsed while gnt=1000 at hold_cnt=4: gnt=0000 on the next edge; afterwards, with req=1001, gnt=0001 because ptr=0.
REQ-031 All tests: a checker SHALL confirm every cycle that gnt is one-hot or zero, and that no two different non-zero grants are adjacent without a 0000 cycle between them.
